// File: rtl/texture_pkg.sv
// rtl/texture_pkg.sv - shared constants for the texture sampler pipeline
// Purpose: wrap-mode encodings and fixed widths used by texture_sampler and
//          texture_coord_wrap.
// Ports:   none (package).
package texture_pkg;

    localparam logic WRAP_REPEAT         = 1'b0;
    localparam logic WRAP_CLAMP_TO_EDGE  = 1'b1;

    localparam int TEX_MAX_SIZE_LOG2     = 8;
    localparam int TEX_ADDR_WIDTH        = 16;
    localparam int TEX_SUB_COORD_WIDTH   = 16;
    // Integer texel coordinate carried from the scale stage (Q16.16 << 8 -> 24 bits).
    localparam int TEX_COORD_WIDTH       = 24;

endpackage

// File: rtl/texture_coord_wrap.sv
// rtl/texture_coord_wrap.sv - combinational REPEAT / CLAMP_TO_EDGE of one texel coordinate
// Purpose: map a signed integer texel coordinate into [0, size-1].
// Ports:   i_coord     - signed integer texel coordinate
//          i_size_log2 - texture dimension log2 (0..8)
//          i_wrap_mode - WRAP_REPEAT or WRAP_CLAMP_TO_EDGE
//          o_index     - wrapped texel index
module texture_coord_wrap
    import texture_pkg::*;
(
    input  logic [TEX_COORD_WIDTH-1:0]   i_coord,
    input  logic [3:0]                   i_size_log2,
    input  logic                         i_wrap_mode,
    output logic [TEX_MAX_SIZE_LOG2-1:0] o_index
);

    logic [TEX_MAX_SIZE_LOG2:0]   w_size;
    logic [TEX_MAX_SIZE_LOG2-1:0] w_mask;
    logic                         w_neg;
    logic                         w_over;

    assign w_size = (TEX_MAX_SIZE_LOG2+1)'(1) << i_size_log2;
    assign w_mask = TEX_MAX_SIZE_LOG2'(w_size - (TEX_MAX_SIZE_LOG2+1)'(1));
    assign w_neg  = i_coord[TEX_COORD_WIDTH-1];
    assign w_over = !w_neg && (i_coord[TEX_COORD_WIDTH-2:0] >=
                    {{(TEX_COORD_WIDTH-TEX_MAX_SIZE_LOG2-2){1'b0}}, w_size});

    always_comb begin
        o_index = i_coord[TEX_MAX_SIZE_LOG2-1:0] & w_mask;
        if (i_wrap_mode != WRAP_REPEAT) begin
            if (w_neg) begin
                o_index = '0;
            end else if (w_over) begin
                o_index = w_mask;
            end else begin
                o_index = i_coord[TEX_MAX_SIZE_LOG2-1:0];
            end
        end
    end

endmodule

// File: rtl/texture_sampler.sv
// rtl/texture_sampler.sv - 2x2 texel neighbourhood address generation and fetch
// Purpose: scale a Q16.16 S/T coordinate to texel space, wrap the four corner
//          coordinates, issue four memory reads and present texels plus
//          sub-texel fractions to the bilinear filter. 3-stage, stalls on m_ready.
// Ports:   aclk/resetn             - clock, synchronous active-low reset
//          conf*                   - quasi-static texture size / wrap / filter config
//          s_valid/s_ready/s_user/s_texelS/s_texelT - input sample stream
//          m_valid/m_ready/m_user/m_texel*/m_texelSubCoord* - output to filter
//          texAddr*/texRdEn/texData* - four-port texture memory (registered read)
module texture_sampler
    import texture_pkg::*;
#(
    parameter int USER_WIDTH  = 1,
    parameter int PIXEL_WIDTH = 32,
    parameter int ADDR_WIDTH  = TEX_ADDR_WIDTH
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic [3:0]                     confWidthLog2,
    input  logic [3:0]                     confHeightLog2,
    input  logic                           confWrapModeS,
    input  logic                           confWrapModeT,
    input  logic                           confEnableFilter,
    output logic                           s_ready,
    input  logic                           s_valid,
    input  logic [USER_WIDTH-1:0]          s_user,
    input  logic [31:0]                    s_texelS,
    input  logic [31:0]                    s_texelT,
    input  logic                           m_ready,
    output logic                           m_valid,
    output logic [USER_WIDTH-1:0]          m_user,
    output logic [PIXEL_WIDTH-1:0]         m_texel00,
    output logic [PIXEL_WIDTH-1:0]         m_texel01,
    output logic [PIXEL_WIDTH-1:0]         m_texel10,
    output logic [PIXEL_WIDTH-1:0]         m_texel11,
    output logic [TEX_SUB_COORD_WIDTH-1:0] m_texelSubCoordS,
    output logic [TEX_SUB_COORD_WIDTH-1:0] m_texelSubCoordT,
    output logic [ADDR_WIDTH-1:0]          texAddr00,
    output logic [ADDR_WIDTH-1:0]          texAddr01,
    output logic [ADDR_WIDTH-1:0]          texAddr10,
    output logic [ADDR_WIDTH-1:0]          texAddr11,
    output logic                           texRdEn,
    input  logic [PIXEL_WIDTH-1:0]         texData00,
    input  logic [PIXEL_WIDTH-1:0]         texData01,
    input  logic [PIXEL_WIDTH-1:0]         texData10,
    input  logic [PIXEL_WIDTH-1:0]         texData11
);

    localparam int IW = TEX_MAX_SIZE_LOG2;
    localparam int FW = TEX_SUB_COORD_WIDTH;

    logic w_ce;
    assign w_ce    = m_ready;
    assign s_ready = m_ready;
    assign texRdEn = m_ready;

    // Stage 1: scale to texel space in 40 bits so an 8-bit shift of Q16.16 cannot overflow.
    logic [39:0] w_half, w_s_scaled, w_t_scaled;
    assign w_half     = confEnableFilter ? 40'h00_0000_8000 : 40'h0;
    assign w_s_scaled = ({{8{s_texelS[31]}}, s_texelS} << confWidthLog2)  - w_half;
    assign w_t_scaled = ({{8{s_texelT[31]}}, s_texelT} << confHeightLog2) - w_half;

    logic                       r1_valid;
    logic [USER_WIDTH-1:0]      r1_user;
    logic [TEX_COORD_WIDTH-1:0] r1_u0, r1_v0;
    logic [FW-1:0]              r1_frac_s, r1_frac_t;

    // Stage 2: wrap the four corners and form addresses.
    logic [TEX_COORD_WIDTH-1:0] w_u1, w_v1;
    logic [IW-1:0]              w_u0_idx, w_u1_idx, w_v0_idx, w_v1_idx;
    assign w_u1 = r1_u0 + TEX_COORD_WIDTH'(1);
    assign w_v1 = r1_v0 + TEX_COORD_WIDTH'(1);

    texture_coord_wrap u_wrap_u0 (.i_coord(r1_u0), .i_size_log2(confWidthLog2),  .i_wrap_mode(confWrapModeS), .o_index(w_u0_idx));
    texture_coord_wrap u_wrap_u1 (.i_coord(w_u1),  .i_size_log2(confWidthLog2),  .i_wrap_mode(confWrapModeS), .o_index(w_u1_idx));
    texture_coord_wrap u_wrap_v0 (.i_coord(r1_v0), .i_size_log2(confHeightLog2), .i_wrap_mode(confWrapModeT), .o_index(w_v0_idx));
    texture_coord_wrap u_wrap_v1 (.i_coord(w_v1),  .i_size_log2(confHeightLog2), .i_wrap_mode(confWrapModeT), .o_index(w_v1_idx));

    logic [ADDR_WIDTH-1:0] w_row0, w_row1, w_col0, w_col1;
    assign w_row0 = {{(ADDR_WIDTH-IW){1'b0}}, w_v0_idx} << confWidthLog2;
    assign w_row1 = {{(ADDR_WIDTH-IW){1'b0}}, w_v1_idx} << confWidthLog2;
    assign w_col0 = {{(ADDR_WIDTH-IW){1'b0}}, w_u0_idx};
    assign w_col1 = {{(ADDR_WIDTH-IW){1'b0}}, w_u1_idx};

    logic                  r2_valid;
    logic [USER_WIDTH-1:0] r2_user;
    logic [FW-1:0]         r2_frac_s, r2_frac_t;

    // Stage 3 sideband; texel data is registered inside the memory itself.
    logic                  r3_valid;
    logic [USER_WIDTH-1:0] r3_user;
    logic [FW-1:0]         r3_frac_s, r3_frac_t;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r1_valid  <= 1'b0;
            r1_user   <= '0;
            r1_u0     <= '0;
            r1_v0     <= '0;
            r1_frac_s <= '0;
            r1_frac_t <= '0;
            r2_valid  <= 1'b0;
            r2_user   <= '0;
            r2_frac_s <= '0;
            r2_frac_t <= '0;
            texAddr00 <= '0;
            texAddr01 <= '0;
            texAddr10 <= '0;
            texAddr11 <= '0;
            r3_valid  <= 1'b0;
            r3_user   <= '0;
            r3_frac_s <= '0;
            r3_frac_t <= '0;
        end else if (w_ce) begin
            r1_valid  <= s_valid;
            r1_user   <= s_user;
            r1_u0     <= w_s_scaled[39:16];
            r1_v0     <= w_t_scaled[39:16];
            r1_frac_s <= w_s_scaled[15:0];
            r1_frac_t <= w_t_scaled[15:0];
            r2_valid  <= r1_valid;
            r2_user   <= r1_user;
            r2_frac_s <= r1_frac_s;
            r2_frac_t <= r1_frac_t;
            texAddr00 <= w_row0 | w_col0;
            texAddr01 <= w_row0 | w_col1;
            texAddr10 <= w_row1 | w_col0;
            texAddr11 <= w_row1 | w_col1;
            r3_valid  <= r2_valid;
            r3_user   <= r2_user;
            r3_frac_s <= r2_frac_s;
            r3_frac_t <= r2_frac_t;
        end
    end

    assign m_valid          = r3_valid;
    assign m_user           = r3_user;
    assign m_texelSubCoordS = r3_frac_s;
    assign m_texelSubCoordT = r3_frac_t;
    assign m_texel00        = texData00;
    assign m_texel01        = texData01;
    assign m_texel10        = texData10;
    assign m_texel11        = texData11;

endmodule

// File: tb/tb_texture_sampler.sv
// tb/tb_texture_sampler.sv - self-checking scoreboard bench for texture_sampler
module tb_texture_sampler;

    logic        aclk = 1'b0;
    logic        resetn;
    logic [3:0]  confWidthLog2, confHeightLog2;
    logic        confWrapModeS, confWrapModeT, confEnableFilter;
    logic        s_ready, s_valid, m_ready, m_valid, texRdEn;
    logic [7:0]  s_user, m_user;
    logic [31:0] s_texelS, s_texelT;
    logic [31:0] m_texel00, m_texel01, m_texel10, m_texel11;
    logic [15:0] m_texelSubCoordS, m_texelSubCoordT;
    logic [15:0] texAddr00, texAddr01, texAddr10, texAddr11;
    logic [31:0] texData00 = '0, texData01 = '0, texData10 = '0, texData11 = '0;

    typedef struct {
        logic [7:0]  user;
        logic [15:0] a00, a01, a10, a11;
        logic [15:0] fs, ft;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;

    always #5 aclk = ~aclk;

    texture_sampler #(.USER_WIDTH(8)) dut (
        .aclk(aclk), .resetn(resetn),
        .confWidthLog2(confWidthLog2), .confHeightLog2(confHeightLog2),
        .confWrapModeS(confWrapModeS), .confWrapModeT(confWrapModeT),
        .confEnableFilter(confEnableFilter),
        .s_ready(s_ready), .s_valid(s_valid), .s_user(s_user),
        .s_texelS(s_texelS), .s_texelT(s_texelT),
        .m_ready(m_ready), .m_valid(m_valid), .m_user(m_user),
        .m_texel00(m_texel00), .m_texel01(m_texel01),
        .m_texel10(m_texel10), .m_texel11(m_texel11),
        .m_texelSubCoordS(m_texelSubCoordS), .m_texelSubCoordT(m_texelSubCoordT),
        .texAddr00(texAddr00), .texAddr01(texAddr01),
        .texAddr10(texAddr10), .texAddr11(texAddr11),
        .texRdEn(texRdEn),
        .texData00(texData00), .texData01(texData01),
        .texData10(texData10), .texData11(texData11)
    );

    // Texel content encodes its own address so fetched data identifies the address used.
    function automatic logic [31:0] tex_val(input logic [15:0] a);
        return {~a, a};
    endfunction

    always @(posedge aclk) begin
        if (texRdEn) begin
            texData00 <= tex_val(texAddr00);
            texData01 <= tex_val(texAddr01);
            texData10 <= tex_val(texAddr10);
            texData11 <= tex_val(texAddr11);
        end
    end

    function automatic int wrapi(input int c, input int lg, input logic clamp);
        int w;
        w = 1 << lg;
        if (clamp) return (c < 0) ? 0 : ((c >= w) ? w - 1 : c);
        return c & (w - 1);
    endfunction

    task automatic push_exp(input logic [7:0] user, input logic [15:0] a00, a01, a10, a11,
                            input logic [15:0] fs, ft);
        exp_t e;
        e.user = user; e.a00 = a00; e.a01 = a01; e.a10 = a10; e.a11 = a11;
        e.fs = fs; e.ft = ft;
        sb.push_back(e);
    endtask

    task automatic push_model(input logic [7:0] user, input logic [31:0] s, input logic [31:0] t);
        longint ss, tt;
        int     u0, v0, ua, ub, va, vb, wl;
        wl = int'(confWidthLog2);
        ss = longint'($signed(s)) * (longint'(1) << confWidthLog2);
        tt = longint'($signed(t)) * (longint'(1) << confHeightLog2);
        if (confEnableFilter) begin
            ss = ss - 32768;
            tt = tt - 32768;
        end
        u0 = int'(ss >>> 16);
        v0 = int'(tt >>> 16);
        ua = wrapi(u0,     wl, confWrapModeS);
        ub = wrapi(u0 + 1, wl, confWrapModeS);
        va = wrapi(v0,     int'(confHeightLog2), confWrapModeT);
        vb = wrapi(v0 + 1, int'(confHeightLog2), confWrapModeT);
        push_exp(user, 16'((va << wl) | ua), 16'((va << wl) | ub),
                 16'((vb << wl) | ua), 16'((vb << wl) | ub), 16'(ss), 16'(tt));
    endtask

    // One clock: drive inputs, then at the falling edge pop/compare any output the filter takes.
    task automatic drive_cycle(input logic v, input logic [7:0] u, input logic [31:0] s,
                               input logic [31:0] t, input logic rdy);
        exp_t e;
        s_valid = v; s_user = u; s_texelS = s; s_texelT = t; m_ready = rdy;
        @(negedge aclk);
        if (m_valid && m_ready) begin
            n_out++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: got user=%0h with empty scoreboard, required none", m_user);
            end else begin
                e = sb.pop_front();
                if ({m_user, m_texel00, m_texel01, m_texel10, m_texel11, m_texelSubCoordS, m_texelSubCoordT} !==
                    {e.user, tex_val(e.a00), tex_val(e.a01), tex_val(e.a10), tex_val(e.a11), e.fs, e.ft}) begin
                    n_bad++;
                    $display("FAIL sample_out: got user=%0h tex=%h/%h/%h/%h frac=%h/%h, required user=%0h tex=%h/%h/%h/%h frac=%h/%h",
                             m_user, m_texel00, m_texel01, m_texel10, m_texel11, m_texelSubCoordS, m_texelSubCoordT,
                             e.user, tex_val(e.a00), tex_val(e.a01), tex_val(e.a10), tex_val(e.a11), e.fs, e.ft);
                end
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) drive_cycle(1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic set_conf(input logic [3:0] wl, input logic [3:0] hl, input logic ws,
                            input logic wt, input logic filt);
        confWidthLog2 = wl; confHeightLog2 = hl;
        confWrapModeS = ws; confWrapModeT = wt; confEnableFilter = filt;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'hAA, 32'h1234_5678, 32'h8765_4321, 1'b1);
        n_cmp++;
        if ({m_valid, m_user, m_texelSubCoordS, m_texelSubCoordT, texAddr00, texAddr01, texAddr10, texAddr11} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got valid=%b user=%h sub=%h/%h addr=%h/%h/%h/%h, required all 0",
                     m_valid, m_user, m_texelSubCoordS, m_texelSubCoordT, texAddr00, texAddr01, texAddr10, texAddr11);
        end
        resetn = 1'b1;
    endtask

    task automatic test_filter_interior();
        set_conf(4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
        push_exp(8'h01, 16'd5, 16'd6, 16'd9, 16'd10, 16'h8000, 16'h8000);
        drive_cycle(1'b1, 8'h01, 32'h0000_8000, 32'h0000_8000, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (m_valid !== (k == 3)) begin
                n_bad++;
                $display("FAIL latency_edge%0d: got m_valid=%b, required %b", k, m_valid, (k == 3));
            end
            if (k < 3) drive_cycle(1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
        end
        drain();
    endtask

    task automatic test_filter_origin();
        set_conf(4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
        push_exp(8'h02, 16'd15, 16'd12, 16'd3, 16'd0, 16'h8000, 16'h8000);
        drive_cycle(1'b1, 8'h02, 32'h0, 32'h0, 1'b1);
        drain();
        set_conf(4'd2, 4'd2, 1'b1, 1'b1, 1'b1);
        push_exp(8'h03, 16'd0, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h8000);
        drive_cycle(1'b1, 8'h03, 32'h0, 32'h0, 1'b1);
        drain();
    endtask

    task automatic test_filter_off_wrap();
        set_conf(4'd3, 4'd1, 1'b0, 1'b0, 1'b0);
        push_exp(8'h04, 16'd2, 16'd3, 16'd10, 16'd11, 16'h0000, 16'h0000);
        drive_cycle(1'b1, 8'h04, 32'h0001_4000, 32'h0, 1'b1);
        drain();
    endtask

    task automatic test_negative_range();
        set_conf(4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
        push_exp(8'h05, 16'd2, 16'd3, 16'd6, 16'd7, 16'h0000, 16'h0000);   // S=-0.5 -> u0=-2 -> 2
        drive_cycle(1'b1, 8'h05, 32'hFFFF_8000, 32'h0, 1'b1);
        push_exp(8'h06, 16'd0, 16'd1, 16'd4, 16'd5, 16'h0000, 16'h0000);   // S=-2.0 -> u0=-8 -> 0
        drive_cycle(1'b1, 8'h06, 32'hFFFE_0000, 32'h0, 1'b1);
        drain();
        set_conf(4'd2, 4'd2, 1'b1, 1'b1, 1'b0);
        push_exp(8'h07, 16'd0, 16'd0, 16'd4, 16'd4, 16'h0000, 16'h0000);
        drive_cycle(1'b1, 8'h07, 32'hFFFF_8000, 32'h0, 1'b1);
        push_exp(8'h08, 16'd0, 16'd0, 16'd4, 16'd4, 16'h0000, 16'h0000);
        drive_cycle(1'b1, 8'h08, 32'hFFFE_0000, 32'h0, 1'b1);
        push_exp(8'h09, 16'd3, 16'd3, 16'd7, 16'd7, 16'h0000, 16'h0000);   // S=3.0 -> u0=12,u1=13 -> 3
        drive_cycle(1'b1, 8'h09, 32'h0003_0000, 32'h0, 1'b1);
        drain();
    endtask

    task automatic test_width_one();
        for (int m = 0; m < 2; m++) begin
            set_conf(4'd0, 4'd0, 1'(m), 1'(m), 1'b0);
            push_exp(8'h0A + 8'(m), 16'd0, 16'd0, 16'd0, 16'd0, 16'h8000, 16'h4000);
            drive_cycle(1'b1, 8'h0A + 8'(m), 32'h0003_8000, 32'hFFFB_4000, 1'b1);
            drain();
        end
    endtask

    task automatic test_stream_stall();
        bit          rp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] sv[8], tv[8];
        int          sent, cyc, out0;
        logic        rdy;
        set_conf(4'd4, 4'd3, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sv[i] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
            tv[i] = 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
        end
        sent = 0; cyc = 0; out0 = n_out;
        while ((sent < 8 || sb.size() != 0) && cyc < 200) begin
            rdy = rp[cyc % 6];
            if (sent < 8) begin
                if (rdy) push_model(8'h40 + 8'(sent), sv[sent], tv[sent]);
                drive_cycle(1'b1, 8'h40 + 8'(sent), sv[sent], tv[sent], rdy);
                if (rdy) sent++;
            end else begin
                drive_cycle(1'b0, 8'h00, 32'h0, 32'h0, rdy);
            end
            n_cmp++;
            if (s_ready !== m_ready || texRdEn !== m_ready) begin
                n_bad++;
                $display("FAIL ready_follow: got s_ready=%b texRdEn=%b, required %b", s_ready, texRdEn, m_ready);
            end
            cyc++;
        end
        n_cmp++;
        if (n_out - out0 != 8) begin
            n_bad++;
            $display("FAIL stream_count: got %0d outputs, required 8", n_out - out0);
        end
    endtask

    task automatic test_reset_midflight();
        set_conf(4'd2, 4'd2, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b1, 8'h50, 32'h0000_8000, 32'h0000_8000, 1'b1);
        drive_cycle(1'b1, 8'h51, 32'h0000_4000, 32'h0000_4000, 1'b1);
        resetn = 1'b0;
        drive_cycle(1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (m_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_drop%0d: got m_valid=%b, required 0", k, m_valid);
            end
            drive_cycle(1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
        end
        push_exp(8'h52, 16'd5, 16'd6, 16'd9, 16'd10, 16'h8000, 16'h8000);
        drive_cycle(1'b1, 8'h52, 32'h0000_8000, 32'h0000_8000, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (m_valid !== (k == 3)) begin
                n_bad++;
                $display("FAIL post_reset_latency%0d: got m_valid=%b, required %b", k, m_valid, (k == 3));
            end
            if (k < 3) drive_cycle(1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
        end
        drain();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL final_drain: got %0d pending, required 0", sb.size());
        end
    endtask

    initial begin
        resetn = 1'b0;
        set_conf(4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
        s_valid = 1'b0; s_user = '0; s_texelS = '0; s_texelT = '0; m_ready = 1'b1;
        @(posedge aclk);
        #1;
        test_reset();
        test_filter_interior();
        test_filter_origin();
        test_filter_off_wrap();
        test_negative_range();
        test_width_one();
        test_stream_stall();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
